dcp_tx_fmt: RTL and testbench

//   Transmit-side responder for the debug-command-processor (DCP) print handshake.

---
 rtl/dcp_tx_fmt.sv | 147 ++++++++++++++
 tb/tb_dcp_tx_fmt.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcp_tx_fmt.sv
// dcp_tx_fmt: transmit-side responder for the DCP print handshake.
// Takes a print request (hex word or raw byte), streams it as ASCII bytes over a
// valid/ready port to the UART transmitter, then pulses ack and waits for the
// requester to drop its request (4-phase handshake).
// Optional build macro: DCP_TX_CRLF_EN appends CR LF after the hex digits.
module dcp_tx_fmt #(
  parameter int HEX_DIGITS = 8,
  parameter bit UPPERCASE  = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_tx,
  input  logic        i_type_tx,
  input  logic [31:0] i_dout,
  output logic        o_ack_tx,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_vld,
  input  logic        i_tx_rdy,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, SEND, ACK, REL} state_t;

`ifdef DCP_TX_CRLF_EN
  localparam int HEX_BYTES = HEX_DIGITS + 2;
`else
  localparam int HEX_BYTES = HEX_DIGITS;
`endif
  localparam logic [3:0] HEX_COUNT   = 4'(HEX_BYTES);
  localparam logic [4:0] LAST_DIGIT  = 5'(HEX_DIGITS - 1);
  localparam logic [7:0] LETTER_BASE = UPPERCASE ? 8'h41 : 8'h61;

  // ASCII byte number idx of a request; digit 0 is the most significant printed nibble
  function automatic logic [7:0] fmtByte(input logic [31:0] payload, input logic rawMode,
                                         input logic [3:0] idx);
    logic [4:0] digitPos;
    logic [3:0] nib;
    fmtByte  = 8'h00;
    digitPos = LAST_DIGIT - {1'b0, idx};
    nib      = 4'(payload >> {digitPos, 2'b00});
    if (rawMode) begin
      fmtByte = payload[7:0];
    end else if ({1'b0, idx} <= LAST_DIGIT) begin
      fmtByte = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (LETTER_BASE + {4'h0, nib} - 8'd10);
    end
`ifdef DCP_TX_CRLF_EN
    else if ({1'b0, idx} == LAST_DIGIT + 5'd1) begin
      fmtByte = 8'h0D;
    end else begin
      fmtByte = 8'h0A;
    end
`endif
  endfunction

  state_t      r_state, w_state;
  logic [31:0] r_payload, w_payload;
  logic        r_raw, w_raw;
  logic [3:0]  r_idx, w_idx;
  logic [3:0]  r_remain, w_remain;
  logic        r_ack, w_ack;
  logic [7:0]  r_tx_data, w_tx_data;
  logic        r_tx_vld, w_tx_vld;
  logic        r_busy, w_busy;

  // Register state, latched request and all outputs; reset drops any stream in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_payload <= 32'h0;
      r_raw     <= 1'b0;
      r_idx     <= 4'h0;
      r_remain  <= 4'h0;
      r_ack     <= 1'b0;
      r_tx_data <= 8'h00;
      r_tx_vld  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_payload <= w_payload;
      r_raw     <= w_raw;
      r_idx     <= w_idx;
      r_remain  <= w_remain;
      r_ack     <= w_ack;
      r_tx_data <= w_tx_data;
      r_tx_vld  <= w_tx_vld;
      r_busy    <= w_busy;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead so they leave flops
  always_comb begin
    w_state   = r_state;
    w_payload = r_payload;
    w_raw     = r_raw;
    w_idx     = r_idx;
    w_remain  = r_remain;
    w_ack     = 1'b0;
    w_tx_data = r_tx_data;
    w_tx_vld  = r_tx_vld;
    unique case (r_state)
      IDLE: begin
        if (i_req_tx) begin
          w_state   = SEND;
          w_payload = i_dout;
          w_raw     = i_type_tx;
          w_idx     = 4'h0;
          w_remain  = i_type_tx ? 4'd1 : HEX_COUNT;
          w_tx_vld  = 1'b1;
          w_tx_data = fmtByte(i_dout, i_type_tx, 4'h0);
        end
      end
      SEND: begin
        if (r_tx_vld && i_tx_rdy) begin
          if (r_remain == 4'd1) begin
            w_state   = ACK;
            w_remain  = 4'h0;
            w_tx_vld  = 1'b0;
            w_tx_data = 8'h00;
            w_ack     = 1'b1;
          end else begin
            w_idx     = r_idx + 4'd1;
            w_remain  = r_remain - 4'd1;
            w_tx_data = fmtByte(r_payload, r_raw, r_idx + 4'd1);
          end
        end
      end
      ACK: begin
        w_state = REL;
      end
      REL: begin
        if (!i_req_tx) begin
          w_state = IDLE;
        end
      end
      default: begin
        w_state = IDLE;
      end
    endcase
    w_busy = (w_state != IDLE);
  end

  assign o_ack_tx  = r_ack;
  assign o_tx_data = r_tx_data;
  assign o_tx_vld  = r_tx_vld;
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_dcp_tx_fmt.sv
// tb_dcp_tx_fmt: self-checking bench for dcp_tx_fmt.
// Instance A uses default parameters; instance B prints 6 lowercase digits.
// Both share stimulus; expected byte streams come from a nibble-arithmetic model.
module tb_dcp_tx_fmt;

  localparam int DIG_A = 8;
  localparam int DIG_B = 6;

  logic        clk = 1'b0;
  logic        rst, req, typeTx, rdy;
  logic [31:0] dout;
  logic        aAck, aVld, aBusy, bAck, bVld, bBusy;
  logic [7:0]  aData, bData;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  logic [7:0] gotA[$], gotB[$];
  int gotCycA[$];
  int ackCntA = 0, ackCntB = 0, ackCycA = 0, idleCycA = 0, vldCntA = 0;
  bit pendA = 1'b0;

  dcp_tx_fmt dutA (
    .i_clk(clk), .i_rst(rst), .i_req_tx(req), .i_type_tx(typeTx), .i_dout(dout),
    .o_ack_tx(aAck), .o_tx_data(aData), .o_tx_vld(aVld), .i_tx_rdy(rdy), .o_busy(aBusy)
  );

  dcp_tx_fmt #(.HEX_DIGITS(DIG_B), .UPPERCASE(1'b0)) dutB (
    .i_clk(clk), .i_rst(rst), .i_req_tx(req), .i_type_tx(typeTx), .i_dout(dout),
    .o_ack_tx(bAck), .o_tx_data(bData), .o_tx_vld(bVld), .i_tx_rdy(rdy), .o_busy(bBusy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record accepted bytes, ack pulses and the return to idle, sampled mid-cycle
  always @(negedge clk) begin
    if (aVld && rdy) begin
      gotA.push_back(aData);
      gotCycA.push_back(cyc);
    end
    if (bVld && rdy) gotB.push_back(bData);
    if (aVld) vldCntA++;
    if (bAck) ackCntB++;
    if (aAck) begin
      ackCntA++;
      ackCycA = cyc;
      pendA = 1'b1;
    end else if (pendA && !aBusy) begin
      idleCycA = cyc;
      pendA = 1'b0;
    end
  end

  // Reference model: how many bytes and which ASCII byte k a request prints
  function automatic int refCount(logic raw, int digits);
    if (raw) return 1;
`ifdef DCP_TX_CRLF_EN
    return digits + 2;
`else
    return digits;
`endif
  endfunction

  function automatic logic [7:0] refByte(logic [31:0] p, logic raw, int digits, bit upper, int k);
    int n;
    if (raw) return p[7:0];
    if (k < digits) begin
      n = int'((p >> (4 * (digits - 1 - k))) & 32'hF);
      if (n < 10) return 8'(48 + n);
      return 8'((upper ? 65 : 97) + n - 10);
    end
    return (k == digits) ? 8'h0D : 8'h0A;
  endfunction

  // Drive one request to completion on both instances; scrambles inputs after acceptance
  task automatic runRequest(input logic [31:0] payload, input logic typ, input bit rndRdy,
                            input int dropAt, input int hold, output int reqCyc,
                            output bit timedOut);
    int a0, b0;
    a0 = ackCntA;
    b0 = ackCntB;
    req = 1'b1;
    typeTx = typ;
    dout = payload;
    rdy = rndRdy ? 1'($urandom_range(0, 1)) : 1'b1;
    reqCyc = cyc;
    timedOut = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (ackCntA != a0 && ackCntB != b0) begin
        timedOut = 1'b0;
        break;
      end
      dout = $urandom;
      typeTx = 1'($urandom);
      if (i + 1 == dropAt) req = 1'b0;
      rdy = rndRdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    rdy = 1'b1;
    repeat (hold) begin @(posedge clk); #1; end
    req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 1'b0; typeTx = 1'b0; dout = 32'h0; rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if (aVld !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_vld_a: got %0b want 0", aVld); end
    vectors++; if (aAck !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ack_a: got %0b want 0", aAck); end
    vectors++; if (aBusy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy_a: got %0b want 0", aBusy); end
    vectors++; if (aData !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_data_a: got %h want 00", aData); end
    vectors++; if (bVld !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_vld_b: got %0b want 0", bVld); end
    vectors++; if (bAck !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ack_b: got %0b want 0", bAck); end
    vectors++; if (bBusy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy_b: got %0b want 0", bBusy); end
    vectors++; if (bData !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_data_b: got %h want 00", bData); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_hex_basic;
    logic [7:0] lit [10];
    int sa, sb, aa, ab, nA, nB, reqCyc;
    bit timedOut;
    lit = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
    sa = gotA.size(); sb = gotB.size(); aa = ackCntA; ab = ackCntB;
    runRequest(32'h1234ABCD, 1'b0, 1'b0, -1, 0, reqCyc, timedOut);
    nA = refCount(1'b0, DIG_A);
    nB = refCount(1'b0, DIG_B);
    vectors++; if (timedOut) begin miscompares++; $display("[TB] FAIL hex_timeout: no ack within bound"); end
    vectors++; if (gotA.size() - sa != nA) begin miscompares++; $display("[TB] FAIL hex_count_a: got %0d want %0d", gotA.size() - sa, nA); end
    for (int k = 0; k < nA && sa + k < gotA.size(); k++) begin
      vectors++; if (gotA[sa + k] !== lit[k]) begin miscompares++; $display("[TB] FAIL hex_byte_a[%0d]: got %h want %h", k, gotA[sa + k], lit[k]); end
      vectors++; if (gotCycA[sa + k] != reqCyc + 1 + k) begin miscompares++; $display("[TB] FAIL hex_cycle_a[%0d]: got %0d want %0d", k, gotCycA[sa + k], reqCyc + 1 + k); end
    end
    vectors++; if (ackCntA - aa != 1) begin miscompares++; $display("[TB] FAIL hex_ackcnt_a: got %0d want 1", ackCntA - aa); end
    vectors++; if (ackCycA != reqCyc + nA + 1) begin miscompares++; $display("[TB] FAIL hex_ackcyc_a: got %0d want %0d", ackCycA, reqCyc + nA + 1); end
    vectors++; if (gotB.size() - sb != nB) begin miscompares++; $display("[TB] FAIL hex_count_b: got %0d want %0d", gotB.size() - sb, nB); end
    for (int k = 0; k < nB && sb + k < gotB.size(); k++) begin
      vectors++; if (gotB[sb + k] !== refByte(32'h1234ABCD, 1'b0, DIG_B, 1'b0, k)) begin miscompares++; $display("[TB] FAIL hex_byte_b[%0d]: got %h want %h", k, gotB[sb + k], refByte(32'h1234ABCD, 1'b0, DIG_B, 1'b0, k)); end
    end
    vectors++; if (ackCntB - ab != 1) begin miscompares++; $display("[TB] FAIL hex_ackcnt_b: got %0d want 1", ackCntB - ab); end
  endtask

  task automatic test_raw;
    int sa, sb, aa, va, reqCyc;
    bit timedOut;
    sa = gotA.size(); sb = gotB.size(); aa = ackCntA; va = vldCntA;
    runRequest(32'hFFFF_FF41, 1'b1, 1'b0, -1, 5, reqCyc, timedOut);
    vectors++; if (timedOut) begin miscompares++; $display("[TB] FAIL raw_timeout: no ack within bound"); end
    vectors++; if (gotA.size() - sa != 1) begin miscompares++; $display("[TB] FAIL raw_count_a: got %0d want 1", gotA.size() - sa); end
    if (gotA.size() > sa) begin
      vectors++; if (gotA[sa] !== 8'h41) begin miscompares++; $display("[TB] FAIL raw_byte_a: got %h want 41", gotA[sa]); end
    end
    vectors++; if (vldCntA - va != 1) begin miscompares++; $display("[TB] FAIL raw_vld_cycles_a: got %0d want 1", vldCntA - va); end
    vectors++; if (ackCntA - aa != 1) begin miscompares++; $display("[TB] FAIL raw_ackcnt_a: got %0d want 1", ackCntA - aa); end
    vectors++; if (ackCycA != reqCyc + 2) begin miscompares++; $display("[TB] FAIL raw_ackcyc_a: got %0d want %0d", ackCycA, reqCyc + 2); end
    vectors++; if (gotB.size() - sb != 1) begin miscompares++; $display("[TB] FAIL raw_count_b: got %0d want 1", gotB.size() - sb); end
    if (gotB.size() > sb) begin
      vectors++; if (gotB[sb] !== 8'h41) begin miscompares++; $display("[TB] FAIL raw_byte_b: got %h want 41", gotB[sb]); end
    end
  endtask

  task automatic test_backpressure;
    int sa, sb, aa, n, nA, nB;
    bit done;
    logic [7:0] expA, expB;
    logic [31:0] p;
    p = 32'h1234ABCD;
    sa = gotA.size(); sb = gotB.size(); aa = ackCntA;
    req = 1'b1; typeTx = 1'b0; dout = p; rdy = 1'b1;
    n = 0;
    while (gotA.size() - sa < 2 && n < 20) begin @(posedge clk); #1; n++; end
    dout = $urandom;
    rdy = 1'b0;
    expA = refByte(p, 1'b0, DIG_A, 1'b1, 2);
    expB = refByte(p, 1'b0, DIG_B, 1'b0, 2);
    repeat (4) begin
      @(negedge clk);
      vectors++; if (aVld !== 1'b1 || aData !== expA) begin miscompares++; $display("[TB] FAIL bp_hold_a: got vld=%0b data=%h want vld=1 data=%h", aVld, aData, expA); end
      vectors++; if (bVld !== 1'b1 || bData !== expB) begin miscompares++; $display("[TB] FAIL bp_hold_b: got vld=%0b data=%h want vld=1 data=%h", bVld, bData, expB); end
      @(posedge clk); #1;
    end
    rdy = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
      if (ackCntA != aa) done = 1'b1;
    end
    req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nA = refCount(1'b0, DIG_A);
    nB = refCount(1'b0, DIG_B);
    vectors++; if (!done) begin miscompares++; $display("[TB] FAIL bp_timeout: no ack within bound"); end
    vectors++; if (gotA.size() - sa != nA) begin miscompares++; $display("[TB] FAIL bp_count_a: got %0d want %0d", gotA.size() - sa, nA); end
    for (int k = 0; k < nA && sa + k < gotA.size(); k++) begin
      vectors++; if (gotA[sa + k] !== refByte(p, 1'b0, DIG_A, 1'b1, k)) begin miscompares++; $display("[TB] FAIL bp_byte_a[%0d]: got %h want %h", k, gotA[sa + k], refByte(p, 1'b0, DIG_A, 1'b1, k)); end
    end
    vectors++; if (gotB.size() - sb != nB) begin miscompares++; $display("[TB] FAIL bp_count_b: got %0d want %0d", gotB.size() - sb, nB); end
    vectors++; if (ackCntA - aa != 1) begin miscompares++; $display("[TB] FAIL bp_ackcnt_a: got %0d want 1", ackCntA - aa); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] lit [8];
    int sa, sb, aa, ab, n, nB, reqCyc;
    bit timedOut;
    lit = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46};
    sa = gotA.size();
    req = 1'b1; typeTx = 1'b0; dout = 32'h1234ABCD; rdy = 1'b1;
    n = 0;
    while (gotA.size() - sa < 4 && n < 20) begin @(posedge clk); #1; n++; end
    vectors++; if (gotA.size() - sa != 4) begin miscompares++; $display("[TB] FAIL rstmid_prefix: got %0d bytes want 4", gotA.size() - sa); end
    rst = 1'b1; rdy = 1'b0; req = 1'b0;
    aa = ackCntA; ab = ackCntB;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (aVld !== 1'b0 || aBusy !== 1'b0 || aAck !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_outs_a: got vld=%0b busy=%0b ack=%0b want 0 0 0", aVld, aBusy, aAck); end
    vectors++; if (bVld !== 1'b0 || bBusy !== 1'b0 || bAck !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_outs_b: got vld=%0b busy=%0b ack=%0b want 0 0 0", bVld, bBusy, bAck); end
    rdy = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    vectors++; if (ackCntA != aa || ackCntB != ab) begin miscompares++; $display("[TB] FAIL rstmid_noack: got %0d/%0d acks want 0/0", ackCntA - aa, ackCntB - ab); end
    sa = gotA.size(); sb = gotB.size();
    runRequest(32'hDEADBEEF, 1'b0, 1'b0, -1, 0, reqCyc, timedOut);
    vectors++; if (timedOut) begin miscompares++; $display("[TB] FAIL rstmid_timeout: no ack within bound"); end
    vectors++; if (gotA.size() - sa != refCount(1'b0, DIG_A)) begin miscompares++; $display("[TB] FAIL rstmid_count_a: got %0d want %0d", gotA.size() - sa, refCount(1'b0, DIG_A)); end
    for (int k = 0; k < 8 && sa + k < gotA.size(); k++) begin
      vectors++; if (gotA[sa + k] !== lit[k]) begin miscompares++; $display("[TB] FAIL rstmid_byte_a[%0d]: got %h want %h", k, gotA[sa + k], lit[k]); end
    end
    nB = refCount(1'b0, DIG_B);
    vectors++; if (gotB.size() - sb != nB) begin miscompares++; $display("[TB] FAIL rstmid_count_b: got %0d want %0d", gotB.size() - sb, nB); end
    for (int k = 0; k < nB && sb + k < gotB.size(); k++) begin
      vectors++; if (gotB[sb + k] !== refByte(32'hDEADBEEF, 1'b0, DIG_B, 1'b0, k)) begin miscompares++; $display("[TB] FAIL rstmid_byte_b[%0d]: got %h want %h", k, gotB[sb + k], refByte(32'hDEADBEEF, 1'b0, DIG_B, 1'b0, k)); end
    end
  endtask

  task automatic test_req_drop;
    logic [7:0] lit [8];
    int sa, sb, aa, ab, nB, reqCyc;
    bit timedOut;
    lit = '{8'h30, 8'h30, 8'h43, 8'h30, 8'h46, 8'h46, 8'h45, 8'h45};
    sa = gotA.size(); sb = gotB.size(); aa = ackCntA; ab = ackCntB;
    runRequest(32'h00C0FFEE, 1'b0, 1'b0, 3, 0, reqCyc, timedOut);
    vectors++; if (timedOut) begin miscompares++; $display("[TB] FAIL drop_timeout: no ack within bound"); end
    vectors++; if (gotA.size() - sa != refCount(1'b0, DIG_A)) begin miscompares++; $display("[TB] FAIL drop_count_a: got %0d want %0d", gotA.size() - sa, refCount(1'b0, DIG_A)); end
    for (int k = 0; k < 8 && sa + k < gotA.size(); k++) begin
      vectors++; if (gotA[sa + k] !== lit[k]) begin miscompares++; $display("[TB] FAIL drop_byte_a[%0d]: got %h want %h", k, gotA[sa + k], lit[k]); end
    end
    nB = refCount(1'b0, DIG_B);
    vectors++; if (gotB.size() - sb != nB) begin miscompares++; $display("[TB] FAIL drop_count_b: got %0d want %0d", gotB.size() - sb, nB); end
    for (int k = 0; k < nB && sb + k < gotB.size(); k++) begin
      vectors++; if (gotB[sb + k] !== refByte(32'h00C0FFEE, 1'b0, DIG_B, 1'b0, k)) begin miscompares++; $display("[TB] FAIL drop_byte_b[%0d]: got %h want %h", k, gotB[sb + k], refByte(32'h00C0FFEE, 1'b0, DIG_B, 1'b0, k)); end
    end
    vectors++; if (ackCntA - aa != 1 || ackCntB - ab != 1) begin miscompares++; $display("[TB] FAIL drop_ackcnt: got %0d/%0d want 1/1", ackCntA - aa, ackCntB - ab); end
    vectors++; if (idleCycA != ackCycA + 2) begin miscompares++; $display("[TB] FAIL drop_idle_a: got cycle %0d want %0d", idleCycA, ackCycA + 2); end
  endtask

  task automatic test_random;
    int sa, sb, aa, ab, nA, nB, dropAt, reqCyc;
    bit timedOut;
    logic [31:0] p;
    logic typ;
    for (int it = 0; it < 25; it++) begin
      p = $urandom;
      typ = ($urandom_range(0, 3) == 0);
      dropAt = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, 6));
      sa = gotA.size(); sb = gotB.size(); aa = ackCntA; ab = ackCntB;
      runRequest(p, typ, 1'b1, dropAt, 0, reqCyc, timedOut);
      nA = refCount(typ, DIG_A);
      nB = refCount(typ, DIG_B);
      vectors++; if (timedOut) begin miscompares++; $display("[TB] FAIL rnd_timeout[%0d]: no ack within bound", it); end
      vectors++; if (gotA.size() - sa != nA) begin miscompares++; $display("[TB] FAIL rnd_count_a[%0d]: got %0d want %0d", it, gotA.size() - sa, nA); end
      for (int k = 0; k < nA && sa + k < gotA.size(); k++) begin
        vectors++; if (gotA[sa + k] !== refByte(p, typ, DIG_A, 1'b1, k)) begin miscompares++; $display("[TB] FAIL rnd_byte_a[%0d][%0d]: got %h want %h", it, k, gotA[sa + k], refByte(p, typ, DIG_A, 1'b1, k)); end
      end
      vectors++; if (gotB.size() - sb != nB) begin miscompares++; $display("[TB] FAIL rnd_count_b[%0d]: got %0d want %0d", it, gotB.size() - sb, nB); end
      for (int k = 0; k < nB && sb + k < gotB.size(); k++) begin
        vectors++; if (gotB[sb + k] !== refByte(p, typ, DIG_B, 1'b0, k)) begin miscompares++; $display("[TB] FAIL rnd_byte_b[%0d][%0d]: got %h want %h", it, k, gotB[sb + k], refByte(p, typ, DIG_B, 1'b0, k)); end
      end
      vectors++; if (ackCntA - aa != 1 || ackCntB - ab != 1) begin miscompares++; $display("[TB] FAIL rnd_ackcnt[%0d]: got %0d/%0d want 1/1", it, ackCntA - aa, ackCntB - ab); end
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; typeTx = 1'b0; dout = 32'h0; rdy = 1'b1;
    $display("[TB] starting dcp_tx_fmt bench");
    test_reset;
    test_hex_basic;
    test_raw;
    test_backpressure;
    test_reset_mid;
    test_req_drop;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
